// File: rtl/seq_detector_param.sv
// Detects a runtime-programmable PAT_LEN-bit pattern on a valid-qualified serial stream (overlap selectable).
// Registered one-cycle match pulse, latency 1 clock; no backpressure, bits are consumed only when in_valid=1.
module seq_detector_param #(
  parameter int                 PAT_LEN  = 5,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 5'b10101,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PAT_LEN-1:0]  pat_r;
  logic [PAT_LEN-1:0]  hist;
  logic [PAT_LEN-1:0]  cand;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_nxt;
  logic                accept;
  logic                armed;
  logic                hit;

  always_comb begin
    accept    = in_valid && !cfg_load;
    cand      = (hist << 1) | PAT_LEN'(in);
    // A compare is only meaningful once this bit completes a full window.
    armed     = (state == FULL) || (fill == FILL_LAST);
    hit       = accept && armed && (cand == pat_r);
    fill_nxt  = fill;
    if (accept) begin
      if (hit) begin
        fill_nxt = overlap ? FILL_MAX : '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + FILL_W'(1);
      end
    end
    if (fill_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (fill_nxt == FILL_MAX) begin
      state_nxt = FULL;
    end else begin
      state_nxt = FILLING;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r       <= PAT_INIT;
      hist        <= '0;
      fill        <= '0;
      state       <= EMPTY;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      if (cfg_load) begin
        pat_r <= cfg_pattern;
        hist  <= '0;
        fill  <= '0;
        state <= EMPTY;
        out   <= 1'b0;
      end else if (in_valid) begin
        hist  <= cand;
        fill  <= fill_nxt;
        state <= state_nxt;
        out   <= hit;
      end else begin
        out   <= 1'b0;
      end

      // Clear wins over the old value but a same-cycle hit still counts.
      if (cnt_clr) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
